amber_cap_ld_seq: RTL and testbench
===================================

// Module: amber_cap_ld_seq
// PURPOSE
//  Capability-load sequencer for CLD* instructions, between the MEM-stage issue point and the dcache read port.
//  Accepts one CLD request: effective address plus authorising capability fields.
//  Checks tag, LC permission and bounds, then reads the 12-word capability image one word at a time.
//  Assembles the image into CR fields and presents one writeback beat to regcr, or a fault.
// PARAMETERS
//  WORD_W    24   dcache word width
//  ADDR_W    48   address / capability base,len,cur width (2 words)
//  CAP_WORDS 12   words per capability image (fixed layout; other values unsupported)
// PORTS
//  r_clk           in   1       clock
//  r_rst           in   1       reset, asynchronous, active-low
//  i_req_valid     in   1       CLD request valid
//  o_req_ready     out  1       request accepted when valid&ready
//  i_req_addr      in   48      effective address (cur + imm) of word 0
//  i_req_crt       in   2       destination CR index
//  i_auth_base     in   48      authorising cap base
//  i_auth_len      in   48      authorising cap length
//  i_auth_perms    in   24      authorising cap perms
//  i_auth_tag      in   1       authorising cap tag
//  i_flush         in   1       pipeline flush; aborts any operation
//  o_dc_rd_valid   out  1       dcache read request
//  i_dc_rd_ready   in   1       dcache accepts request
//  o_dc_rd_addr    out  48      word address of request
//  i_dc_rsp_valid  in   1       read data valid (in-order, one per request)
//  i_dc_rsp_data   in   24      read data
//  o_wb_valid      out  1       1-cycle writeback pulse to regcr
//  o_wb_crt        out  2       destination CR
//  o_wb_base/len/cur out 48     assembled fields {hi,lo}
//  o_wb_perms      out  24      perms (word 6)
//  o_wb_attr       out  24      attr (word 8)
//  o_wb_tag        out  1       tag = word 10 bit 0
//  o_fault_valid   out  1       1-cycle fault pulse
//  o_fault_code    out  2       1=tag clear, 2=no LC perm, 3=bounds
//  o_busy          out  1       state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, idx=0, drop=0; all o_* = 0, except o_req_ready=1.
//  States:
//   IDLE: ready=1. On valid: latch request, go to CHECK.
//   CHECK: 1 cycle. Priority: tag==0 -> FAULT(1); perms[CR_PERM_LC_BIT]==0 -> FAULT(2);
//     addr<base or addr+12 > base+len -> FAULT(3). Compare at 49 bits, no wrap. Otherwise go to ISSUE with idx=0.
//   ISSUE: rd_valid=1, rd_addr=addr+idx; hold stable until ready. On accept -> WAIT.
//   WAIT: on rsp_valid, store word[idx]. If idx==11 -> DONE, else idx++ and go to ISSUE.
//   DONE: wb_valid=1 for 1 cycle -> IDLE.
//   FAULT: fault_valid=1 for 1 cycle, no wb -> IDLE.
//  Word map:
//   base = {w1,w0}, len = {w3,w2}, cur = {w5,w4}, perms = w6, attr = w8, tag = w10[0].
//   w7, w9, w11 and w10[23:1] are ignored.
//  o_wb_* and o_fault_code hold their last value until the next assembly or fault. Never X after reset.
//  Latency: with ready=1 and rsp one cycle after accept, wb_valid comes 26 cycles after acceptance
//   (1 CHECK + 12x2 + DONE at cycle 26). A fault comes at cycle 2.
//  At most one dcache request is outstanding.
//  i_flush: highest priority in every state -> IDLE, no wb or fault pulse.
//   Flush in WAIT: set drop=1. The next rsp_valid is discarded and clears drop.
//   A new request may be accepted while drop=1. Its CHECK/ISSUE proceeds, but WAIT ignores the first rsp while drop=1.
//   Flush in ISSUE with same-cycle rd_ready: the request counts as accepted, so drop=1.
//  i_flush and i_req_valid in the same cycle: request is not accepted.
//  rsp_valid outside WAIT with drop=0 is a protocol error; ignore it.
// STRUCTURE
//  Shared header src/cr.vh holds CR_PERM_LC_BIT, CAP_WORDS, CLD_FAULT_* codes and state encodings.
//  Sub-module amber_cap_unpack is combinational: 12x24 image -> CR fields. It is reused by the CST path for packing.
//  Rest: FSM, 4-bit idx counter, 12x24 word buffer, drop flag.
// TESTING
//  1 Auth cap base0 len1000 LC tag1, addr500, mem[500..511]=42,7,88,9,123,3,EE,0,AA,0,1,0
//    -> wb crt1 base=h000007_00002A, len={9,88}, cur={3,123}, perms EE, attr AA, tag1, at cycle 26.
//  2 Auth tag=0 -> fault code1 at cycle 2, zero dcache requests. LC clear -> code2. addr=989 len1000 -> code3.
//    addr=988 -> passes (exact bound).
//  3 rd_ready low 3 cycles per word -> rd_addr/rd_valid held stable, addresses 500..511 in order, wb still correct.
//  4 Flush in WAIT at idx5, new request issued immediately, stale rsp arrives -> discarded.
//    The new load gets correct words, no wb for the first request.
//  5 Async r_rst low mid-ISSUE, between clock edges -> outputs zero immediately. After release, test 1 passes.
//  6 Image w10=h000000 -> wb tag0. Back-to-back requests -> ready low while busy, second wb follows.

Source files
------------

// File: rtl/amber_cap_ld_seq_pkg.sv
// Shared constants and types for the capability-load sequencer.
// The capability image layout and CR field bundle live here.
package amber_cap_ld_seq_pkg;

    localparam int WORD_W         = 24;
    localparam int ADDR_W         = 48;
    localparam int CAP_WORDS      = 12;
    localparam int CR_PERM_LC_BIT = 3;

    localparam logic [1:0] CLD_FAULT_NONE   = 2'd0;
    localparam logic [1:0] CLD_FAULT_TAG    = 2'd1;
    localparam logic [1:0] CLD_FAULT_PERM   = 2'd2;
    localparam logic [1:0] CLD_FAULT_BOUNDS = 2'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_FAULT = 3'd5;

    typedef logic [CAP_WORDS-1:0][WORD_W-1:0] cap_img_t;

    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] len;
        logic [ADDR_W-1:0] cur;
        logic [WORD_W-1:0] perms;
        logic [WORD_W-1:0] attr;
        logic              tag;
    } cr_fields_t;

endpackage

// File: rtl/amber_cap_unpack.sv
// Combinational map from a 12-word capability image to CR fields.
// Words 7, 9, 11 and the upper bits of word 10 carry nothing.
module amber_cap_unpack
    import amber_cap_ld_seq_pkg::*;
(
    input  cap_img_t   img_i,
    output cr_fields_t cr_o
);

    logic unused_words;

    assign cr_o.base  = {img_i[1], img_i[0]};
    assign cr_o.len   = {img_i[3], img_i[2]};
    assign cr_o.cur   = {img_i[5], img_i[4]};
    assign cr_o.perms = img_i[6];
    assign cr_o.attr  = img_i[8];
    assign cr_o.tag   = img_i[10][0];

    assign unused_words = ^{img_i[7], img_i[9], img_i[11],
                            img_i[10][WORD_W-1:1]};

endmodule

// File: rtl/amber_cap_ld_seq.sv
// CLD sequencer: authorise, fetch 12 image words from dcache,
// then emit one CR writeback beat or a fault pulse.
module amber_cap_ld_seq
    import amber_cap_ld_seq_pkg::*;
(
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [1:0]        i_req_crt,
    input  logic [ADDR_W-1:0] i_auth_base,
    input  logic [ADDR_W-1:0] i_auth_len,
    input  logic [WORD_W-1:0] i_auth_perms,
    input  logic              i_auth_tag,
    input  logic              i_flush,
    output logic              o_dc_rd_valid,
    input  logic              i_dc_rd_ready,
    output logic [ADDR_W-1:0] o_dc_rd_addr,
    input  logic              i_dc_rsp_valid,
    input  logic [WORD_W-1:0] i_dc_rsp_data,
    output logic              o_wb_valid,
    output logic [1:0]        o_wb_crt,
    output logic [ADDR_W-1:0] o_wb_base,
    output logic [ADDR_W-1:0] o_wb_len,
    output logic [ADDR_W-1:0] o_wb_cur,
    output logic [WORD_W-1:0] o_wb_perms,
    output logic [WORD_W-1:0] o_wb_attr,
    output logic              o_wb_tag,
    output logic              o_fault_valid,
    output logic [1:0]        o_fault_code,
    output logic              o_busy
);

    logic [2:0]        state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic              drop_q, drop_d;
    logic [1:0]        fcode_q, fcode_d;
    logic [ADDR_W-1:0] addr_q, base_q, len_q;
    logic [WORD_W-1:0] perms_q;
    logic              tag_q;
    logic [1:0]        crt_q, wb_crt_q;
    cap_img_t          img_q, img_d;
    cr_fields_t        cr_w, wb_q;

    logic              accept, rd_fire, rsp_take, load_wb;
    logic [ADDR_W:0]   end_chk, lim_chk;

    assign accept   = i_req_valid & (state_q == ST_IDLE) & ~i_flush;
    assign rd_fire  = (state_q == ST_ISSUE) & i_dc_rd_ready;
    assign rsp_take = (state_q == ST_WAIT) & i_dc_rsp_valid & ~drop_q;
    assign load_wb  = rsp_take & (idx_q == 4'(CAP_WORDS - 1)) & ~i_flush;

    // Bounds compared one bit wider so base+len cannot wrap.
    assign end_chk = {1'b0, addr_q} + (ADDR_W + 1)'(CAP_WORDS);
    assign lim_chk = {1'b0, base_q} + {1'b0, len_q};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        img_d   = img_q;
        fcode_d = fcode_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (!tag_q) begin
                    state_d = ST_FAULT;
                    fcode_d = CLD_FAULT_TAG;
                end else if (!perms_q[CR_PERM_LC_BIT]) begin
                    state_d = ST_FAULT;
                    fcode_d = CLD_FAULT_PERM;
                end else if (addr_q < base_q || end_chk > lim_chk) begin
                    state_d = ST_FAULT;
                    fcode_d = CLD_FAULT_BOUNDS;
                end else begin
                    state_d = ST_ISSUE;
                    idx_d   = 4'd0;
                end
            end
            ST_ISSUE: begin
                if (rd_fire) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (rsp_take) begin
                    img_d[idx_q] = i_dc_rsp_data;
                    if (idx_q == 4'(CAP_WORDS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (i_flush) begin
            state_d = ST_IDLE;
            fcode_d = fcode_q;
        end
    end

    // A flushed in-flight read still returns; its response is owed a discard.
    always_comb begin
        drop_d = drop_q;
        if (i_dc_rsp_valid && drop_q) drop_d = 1'b0;
        if (i_flush) begin
            if (state_q == ST_WAIT && !rsp_take) drop_d = 1'b1;
            if (rd_fire) drop_d = 1'b1;
        end
    end

    amber_cap_unpack u_unpack (
        .img_i (img_d),
        .cr_o  (cr_w)
    );

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            drop_q   <= 1'b0;
            fcode_q  <= CLD_FAULT_NONE;
            addr_q   <= '0;
            base_q   <= '0;
            len_q    <= '0;
            perms_q  <= '0;
            tag_q    <= 1'b0;
            crt_q    <= '0;
            img_q    <= '0;
            wb_q     <= '0;
            wb_crt_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
            fcode_q <= fcode_d;
            img_q   <= img_d;
            if (accept) begin
                addr_q  <= i_req_addr;
                base_q  <= i_auth_base;
                len_q   <= i_auth_len;
                perms_q <= i_auth_perms;
                tag_q   <= i_auth_tag;
                crt_q   <= i_req_crt;
            end
            if (load_wb) begin
                wb_q     <= cr_w;
                wb_crt_q <= crt_q;
            end
        end
    end

    assign o_req_ready   = (state_q == ST_IDLE);
    assign o_busy        = (state_q != ST_IDLE);
    assign o_dc_rd_valid = (state_q == ST_ISSUE);
    assign o_dc_rd_addr  = addr_q + ADDR_W'(idx_q);
    assign o_wb_valid    = (state_q == ST_DONE) & ~i_flush;
    assign o_fault_valid = (state_q == ST_FAULT) & ~i_flush;
    assign o_fault_code  = fcode_q;
    assign o_wb_crt      = wb_crt_q;
    assign o_wb_base     = wb_q.base;
    assign o_wb_len      = wb_q.len;
    assign o_wb_cur      = wb_q.cur;
    assign o_wb_perms    = wb_q.perms;
    assign o_wb_attr     = wb_q.attr;
    assign o_wb_tag      = wb_q.tag;

endmodule

// File: tb/tb_amber_cap_ld_seq.sv
// Scoreboard bench for amber_cap_ld_seq with a dcache responder model.
// Expected writebacks/faults are queued at request acceptance.
module tb_amber_cap_ld_seq;
    import amber_cap_ld_seq_pkg::*;

    logic        r_clk = 0;
    logic        r_rst = 0;
    logic        i_req_valid = 0;
    logic        o_req_ready;
    logic [47:0] i_req_addr = 0;
    logic [1:0]  i_req_crt = 0;
    logic [47:0] i_auth_base = 0;
    logic [47:0] i_auth_len = 0;
    logic [23:0] i_auth_perms = 0;
    logic        i_auth_tag = 0;
    logic        i_flush = 0;
    logic        o_dc_rd_valid;
    logic        i_dc_rd_ready;
    logic [47:0] o_dc_rd_addr;
    logic        i_dc_rsp_valid;
    logic [23:0] i_dc_rsp_data;
    logic        o_wb_valid;
    logic [1:0]  o_wb_crt;
    logic [47:0] o_wb_base, o_wb_len, o_wb_cur;
    logic [23:0] o_wb_perms, o_wb_attr;
    logic        o_wb_tag;
    logic        o_fault_valid;
    logic [1:0]  o_fault_code;
    logic        o_busy;

    amber_cap_ld_seq dut (
        .r_clk(r_clk), .r_rst(r_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_crt(i_req_crt),
        .i_auth_base(i_auth_base), .i_auth_len(i_auth_len),
        .i_auth_perms(i_auth_perms), .i_auth_tag(i_auth_tag),
        .i_flush(i_flush),
        .o_dc_rd_valid(o_dc_rd_valid), .i_dc_rd_ready(i_dc_rd_ready),
        .o_dc_rd_addr(o_dc_rd_addr),
        .i_dc_rsp_valid(i_dc_rsp_valid), .i_dc_rsp_data(i_dc_rsp_data),
        .o_wb_valid(o_wb_valid), .o_wb_crt(o_wb_crt),
        .o_wb_base(o_wb_base), .o_wb_len(o_wb_len), .o_wb_cur(o_wb_cur),
        .o_wb_perms(o_wb_perms), .o_wb_attr(o_wb_attr), .o_wb_tag(o_wb_tag),
        .o_fault_valid(o_fault_valid), .o_fault_code(o_fault_code),
        .o_busy(o_busy)
    );

    always #5 r_clk = ~r_clk;

    typedef struct {
        logic        flt;
        logic [1:0]  code;
        logic [1:0]  crt;
        logic [47:0] base, len, cur;
        logic [23:0] perms, attr;
        logic        tag;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        exp_q[$];
    logic [47:0] acc_q[$];
    logic [23:0] mem[4096];
    int          n_chk = 0, n_fail = 0;
    int          cyc = 0, reqs = 0, stall_n = 0, cnt = 0;
    logic        hold = 0, chk_ord = 0;
    logic [47:0] nxt = 0;
    logic        hs, pv = 0, phs = 0;
    logic [47:0] pa = 0, ra;

    localparam logic [23:0] LC = 24'h1 << CR_PERM_LC_BIT;

    always @(posedge r_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk_ld(input int a, input logic [1:0] crt,
                                   input int lat, input int t0);
        exp_t e;
        e.flt = 0; e.code = 0; e.crt = crt;
        e.base = {mem[a+1], mem[a]};
        e.len  = {mem[a+3], mem[a+2]};
        e.cur  = {mem[a+5], mem[a+4]};
        e.perms = mem[a+6];
        e.attr  = mem[a+8];
        e.tag   = mem[a+10][0];
        e.lat = lat; e.t0 = t0;
        return e;
    endfunction

    function automatic exp_t mk_flt(input logic [1:0] code, input int t0);
        exp_t e;
        e = '{default: 0};
        e.flt = 1; e.code = code; e.lat = 2; e.t0 = t0;
        return e;
    endfunction

    // dcache model: in-order, one response the cycle after accept
    initial begin
        i_dc_rd_ready = 0; i_dc_rsp_valid = 0; i_dc_rsp_data = 0;
        forever begin
            @(negedge r_clk); #3;
            hs = r_rst && o_dc_rd_valid && i_dc_rd_ready;
            if (r_rst && o_dc_rd_valid && pv && !phs)
                chk("rd_addr_stable", o_dc_rd_addr, pa);
            pv = r_rst && o_dc_rd_valid; phs = hs; pa = o_dc_rd_addr;
            ra = o_dc_rd_addr;
            @(posedge r_clk); #1;
            if (hs) begin
                acc_q.push_back(ra); reqs++; cnt = 0;
                if (chk_ord) begin
                    chk("rd_order", ra, nxt); nxt++;
                end
            end
            if (!hold && acc_q.size() > 0) begin
                ra = acc_q.pop_front();
                i_dc_rsp_valid = 1; i_dc_rsp_data = mem[ra[11:0]];
            end else begin
                i_dc_rsp_valid = 0;
            end
            if (o_dc_rd_valid && cnt >= stall_n) i_dc_rd_ready = 1;
            else begin
                i_dc_rd_ready = 0;
                if (o_dc_rd_valid) cnt++;
            end
        end
    end

    // output monitor / scoreboard pop
    initial forever begin
        exp_t e;
        @(negedge r_clk);
        if (r_rst && (o_wb_valid || o_fault_valid)) begin
            if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("kind_fault", o_fault_valid, e.flt);
                chk("kind_wb", o_wb_valid, !e.flt);
                if (e.flt) chk("fault_code", o_fault_code, e.code);
                else begin
                    chk("wb_crt", o_wb_crt, e.crt);
                    chk("wb_base", o_wb_base, e.base);
                    chk("wb_len", o_wb_len, e.len);
                    chk("wb_cur", o_wb_cur, e.cur);
                    chk("wb_perms", o_wb_perms, e.perms);
                    chk("wb_attr", o_wb_attr, e.attr);
                    chk("wb_tag", o_wb_tag, e.tag);
                end
                if (e.lat != 0) chk("latency", cyc - e.t0 + 1, e.lat);
            end
        end
    end

    task automatic send_req(input logic [47:0] a, input logic [1:0] crt,
                            input logic [47:0] b, input logic [47:0] l,
                            input logic [23:0] p, input logic t,
                            output int ta);
        logic ok;
        ok = 0; ta = 0;
        i_req_valid = 1; i_req_addr = a; i_req_crt = crt;
        i_auth_base = b; i_auth_len = l; i_auth_perms = p; i_auth_tag = t;
        for (int k = 0; k < 300; k++) begin
            if (o_req_ready) begin
                @(posedge r_clk); #1;
                ok = 1; ta = cyc;
                break;
            end
            @(negedge r_clk);
        end
        i_req_valid = 0;
        chk("req_accept", ok, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0 && !o_busy) break;
            @(negedge r_clk);
        end
        chk("drain", exp_q.size(), 0);
        @(negedge r_clk);
    endtask

    task automatic test1();
        int ta;
        exp_t e;
        send_req(500, 1, 0, 1000, LC, 1, ta);
        e = '{default: 0};
        e.crt = 1; e.base = 48'h000007_00002A;
        e.len = {24'd9, 24'd88}; e.cur = {24'd3, 24'd123};
        e.perms = 24'hEE; e.attr = 24'hAA; e.tag = 1;
        e.lat = 26; e.t0 = ta;
        exp_q.push_back(e);
        drain();
    endtask

    initial begin
        int ta, n0;
        exp_t e;
        for (int i = 0; i < 4096; i++) mem[i] = 24'($urandom);
        begin
            int img[12] = '{42, 7, 88, 9, 123, 3, 'hEE, 0, 'hAA, 0, 1, 0};
            for (int i = 0; i < 12; i++) mem[500 + i] = 24'(img[i]);
        end
        mem[710] = 24'h000000;
        mem[611] = 24'h000001;

        #1;
        chk("rst_ready", o_req_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_rd_valid", o_dc_rd_valid, 0);
        chk("rst_wb_valid", o_wb_valid, 0);
        chk("rst_wb_base", o_wb_base, 0);
        chk("rst_fault", {o_fault_valid, o_fault_code}, 0);
        repeat (2) @(negedge r_clk);
        r_rst = 1;
        @(negedge r_clk);

        // 1: nominal load with fixed latency
        test1();
        repeat (3) @(negedge r_clk);
        chk("wb_hold_base", o_wb_base, 48'h000007_00002A);

        // 2: fault priorities and exact bound
        n0 = reqs;
        send_req(500, 0, 0, 1000, LC, 0, ta);
        exp_q.push_back(mk_flt(CLD_FAULT_TAG, ta)); drain();
        send_req(500, 0, 0, 1000, ~LC, 0, ta);
        exp_q.push_back(mk_flt(CLD_FAULT_TAG, ta)); drain();
        send_req(500, 0, 0, 1000, ~LC, 1, ta);
        exp_q.push_back(mk_flt(CLD_FAULT_PERM, ta)); drain();
        send_req(989, 0, 0, 1000, LC, 1, ta);
        exp_q.push_back(mk_flt(CLD_FAULT_BOUNDS, ta)); drain();
        send_req(50, 0, 100, 1000, LC, 1, ta);
        exp_q.push_back(mk_flt(CLD_FAULT_BOUNDS, ta)); drain();
        chk("fault_no_dc_reqs", reqs, n0);
        send_req(988, 2, 0, 1000, LC, 1, ta);
        exp_q.push_back(mk_ld(988, 2, 26, ta)); drain();

        // flush together with request: not accepted
        i_req_valid = 1; i_flush = 1; i_req_addr = 500;
        i_auth_tag = 1; i_auth_perms = LC; i_auth_len = 1000;
        @(posedge r_clk); #1;
        i_req_valid = 0; i_flush = 0;
        chk("flush_blocks_req", o_busy, 0);
        @(negedge r_clk);

        // 3: stalled read port, ordered stable addresses
        stall_n = 3; chk_ord = 1; nxt = 500;
        send_req(500, 3, 0, 1000, LC, 1, ta);
        exp_q.push_back(mk_ld(500, 3, 0, ta)); drain();
        chk("stall_last_addr", nxt, 512);
        chk_ord = 0; stall_n = 0;

        // 4: flush in WAIT at idx5, stale response must be dropped
        send_req(500, 1, 0, 1000, LC, 1, ta);
        for (int k = 0; k < 100; k++) begin
            if (o_dc_rd_valid && o_dc_rd_addr == 505) break;
            @(negedge r_clk);
        end
        chk("t4_issue5", o_dc_rd_addr, 505);
        hold = 1;
        @(negedge r_clk);
        chk("t4_in_wait", {o_busy, o_dc_rd_valid}, 2'b10);
        i_flush = 1;
        @(negedge r_clk);
        i_flush = 0;
        chk("t4_flushed", o_busy, 0);
        n0 = reqs;
        send_req(600, 2, 0, 1000, LC, 1, ta);
        exp_q.push_back(mk_ld(600, 2, 0, ta));
        for (int k = 0; k < 50; k++) begin
            if (reqs > n0) break;
            @(negedge r_clk);
        end
        chk("t4_new_issue", reqs, n0 + 1);
        hold = 0;
        drain();

        // 5: async reset mid-ISSUE
        stall_n = 3;
        send_req(500, 1, 0, 1000, LC, 1, ta);
        for (int k = 0; k < 100; k++) begin
            if (o_dc_rd_valid && o_dc_rd_addr == 502) break;
            @(negedge r_clk);
        end
        #2 r_rst = 0;
        acc_q.delete();
        #1;
        chk("arst_busy", o_busy, 0);
        chk("arst_rd_valid", o_dc_rd_valid, 0);
        chk("arst_ready", o_req_ready, 1);
        chk("arst_wb_base", o_wb_base, 0);
        chk("arst_fault_code", o_fault_code, 0);
        exp_q.delete();
        @(negedge r_clk);
        r_rst = 1; stall_n = 0;
        @(negedge r_clk);
        test1();

        // 6: tag-clear image, back-to-back requests
        send_req(700, 3, 0, 1000, LC, 1, ta);
        e = mk_ld(700, 3, 26, ta);
        exp_q.push_back(e);
        chk("t6_exp_tag0", e.tag, 0);
        @(negedge r_clk);
        chk("busy_not_ready", {o_busy, o_req_ready}, 2'b10);
        send_req(500, 0, 0, 1000, LC, 1, ta);
        exp_q.push_back(mk_ld(500, 0, 26, ta));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
